fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 98 +++++++++
 tb/tb_fetch_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: two-entry instruction fetch queue between the PC stage, instruction memory and decode.
// Ports: clock/resetN (async active-low); fetchAddress/addrValid/addrReady from the PC stage;
// flush on a taken branch; memReq*/memResp* single-outstanding memory read; instrValid/instruction/
// instrPC/instrReady toward decode; alignFault pulses when an accepted address is misaligned.
module fetch_queue (
    input  logic        clock,
    input  logic        resetN,
    input  logic [31:0] fetchAddress,
    input  logic        addrValid,
    output logic        addrReady,
    input  logic        flush,
    output logic        memReqValid,
    output logic [31:0] memReqAddr,
    input  logic        memReqReady,
    input  logic        memRespValid,
    input  logic [31:0] memRespData,
    output logic        instrValid,
    output logic [31:0] instruction,
    output logic [31:0] instrPC,
    input  logic        instrReady,
    output logic        alignFault
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DROP = 2'd3;
    logic [1:0]  state_q, state_d, count_q, count_d;
    logic        head_q, head_d, tail_q, tail_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        align_q, align_d, stale_q, stale_d;
    logic [31:0] pc_q [2];
    logic [31:0] pc_d [2];
    logic [31:0] ins_q [2];
    logic [31:0] ins_d [2];
    logic        accept, push, pop;
    // Gating with resetN keeps addrReady low while reset is held.
    assign addrReady   = resetN && state_q == IDLE && count_q != 2'd2 && !flush;
    assign accept      = addrValid && addrReady;
    assign push        = state_q == WAIT && memRespValid && !flush;
    assign pop         = instrValid && instrReady;
    assign memReqValid = state_q == REQ;
    assign memReqAddr  = req_addr_q;
    assign instrValid  = count_q != 2'd0;
    assign instruction = ins_q[head_q];
    assign instrPC     = pc_q[head_q];
    assign alignFault  = align_q;
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = accept ? REQ : IDLE;
            REQ:     state_d = memReqReady ? (flush ? DROP : WAIT) : (flush ? IDLE : REQ);
            WAIT:    state_d = memRespValid ? IDLE : (flush ? DROP : WAIT);
            default: state_d = memRespValid ? IDLE : DROP;
        endcase
        count_d    = flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
        head_d     = flush ? 1'b0 : head_q ^ pop;
        tail_d     = flush ? 1'b0 : tail_q ^ push;
        req_addr_d = accept ? {fetchAddress[31:2], 2'b00} : req_addr_q;
        align_d    = accept && fetchAddress[1:0] != 2'b00;
        // A read abandoned by reset can only answer before memory accepts our next request,
        // so the stale window closes on the first response or the first request handshake.
        stale_d    = stale_q && !memRespValid && !(memReqValid && memReqReady);
        pc_d       = pc_q;
        ins_d      = ins_q;
        if (push) begin
            pc_d[tail_q]  = req_addr_q;
            ins_d[tail_q] = memRespData;
        end
    end
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            count_q    <= 2'd0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            req_addr_q <= 32'd0;
            align_q    <= 1'b0;
            stale_q    <= 1'b1;
            pc_q       <= '{default: '0};
            ins_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            req_addr_q <= req_addr_d;
            align_q    <= align_d;
            stale_q    <= stale_d;
            pc_q       <= pc_d;
            ins_q      <= ins_d;
        end
    end
    a_no_push_full: assert property (@(posedge clock) disable iff (!resetN)
        !(push && count_q == 2'd2)) else $error("push into full fetch queue");
    a_resp_in_window: assert property (@(posedge clock) disable iff (!resetN)
        !(memRespValid && !stale_q && (state_q == IDLE || state_q == REQ)))
        else $error("memory response with no outstanding read");
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table plus hand-written corner sequences for fetch_queue.
module tb_fetch_queue;
    logic        clock, resetN, addrValid, addrReady, flush, memReqValid, memReqReady;
    logic        memRespValid, instrValid, instrReady, alignFault;
    logic [31:0] fetchAddress, memReqAddr, memRespData, instruction, instrPC;
    int          tests = 0;
    int          fails = 0;
    typedef struct {
        logic        av;
        logic [31:0] addr;
        logic        fl, mrr, mrv;
        logic [31:0] md;
        logic        ir, ar, mqv;
        logic [31:0] mqa;
        logic        iv;
        logic [31:0] ins, ipc;
        logic        af;
    } vec_t;
    vec_t vec[$];
    fetch_queue dut (
        .clock(clock), .resetN(resetN), .fetchAddress(fetchAddress), .addrValid(addrValid),
        .addrReady(addrReady), .flush(flush), .memReqValid(memReqValid), .memReqAddr(memReqAddr),
        .memReqReady(memReqReady), .memRespValid(memRespValid), .memRespData(memRespData),
        .instrValid(instrValid), .instruction(instruction), .instrPC(instrPC),
        .instrReady(instrReady), .alignFault(alignFault)
    );
    initial clock = 1'b0;
    always #5 clock = ~clock;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask
    task automatic v(input logic av, input logic [31:0] addr, input logic fl, input logic mrr,
                     input logic mrv, input logic [31:0] md, input logic ir, input logic ar,
                     input logic mqv, input logic [31:0] mqa, input logic iv,
                     input logic [31:0] ins, input logic [31:0] ipc, input logic af);
        vec.push_back('{av, addr, fl, mrr, mrv, md, ir, ar, mqv, mqa, iv, ins, ipc, af});
    endtask
    task automatic step();
        @(posedge clock);
        #1;
    endtask
    task automatic idle_inputs();
        addrValid = 0; fetchAddress = 0; flush = 0; memReqReady = 0;
        memRespValid = 0; memRespData = 0; instrReady = 0;
    endtask
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
        addrValid = 1; fetchAddress = addr;
        step();
        addrValid = 0; memReqReady = 1;
        step();
        memReqReady = 0; memRespValid = 1; memRespData = data;
        step();
        memRespValid = 0;
    endtask
    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_mqv"}, memReqValid, 0);
        chk({tag, "_mqa"}, memReqAddr, 0);
        chk({tag, "_iv"}, instrValid, 0);
        chk({tag, "_ins"}, instruction, 0);
        chk({tag, "_ipc"}, instrPC, 0);
        chk({tag, "_af"}, alignFault, 0);
        chk({tag, "_ar"}, addrReady, 0);
    endtask
    initial begin
        // basic fetch
        v(1,'h100,0,0,0,0,0,            1,1,'h100,0,0,0,0);
        v(0,0,0,1,0,0,0,                0,0,'h100,0,0,0,0);
        v(0,0,0,0,1,'h8B020020,0,       0,0,'h100,1,'h8B020020,'h100,0);
        v(0,0,0,0,0,0,1,                1,0,'h100,0,0,0,0);
        // backpressure: 0x0, 0x4 fill the queue, 0x8 waits for a pop
        v(1,0,0,0,0,0,0,                1,1,0,0,0,0,0);
        v(0,0,0,1,0,0,0,                0,0,0,0,0,0,0);
        v(0,0,0,0,1,'h11111111,0,       0,0,0,1,'h11111111,0,0);
        v(1,4,0,0,0,0,0,                1,1,4,1,'h11111111,0,0);
        v(0,0,0,1,0,0,0,                0,0,4,1,'h11111111,0,0);
        v(0,0,0,0,1,'h22222222,0,       0,0,4,1,'h11111111,0,0);
        v(1,8,0,0,0,0,0,                0,0,4,1,'h11111111,0,0);
        v(1,8,0,0,0,0,1,                0,0,4,1,'h22222222,4,0);
        v(1,8,0,0,0,0,0,                1,1,8,1,'h22222222,4,0);
        v(0,0,0,1,0,0,0,                0,0,8,1,'h22222222,4,0);
        v(0,0,0,0,1,'h33333333,1,       0,0,8,1,'h33333333,8,0);
        v(0,0,0,0,0,0,1,                1,0,8,0,'h22222222,4,0);
        // misaligned address
        v(1,'h103,0,0,0,0,0,            1,1,'h100,0,'h22222222,4,1);
        v(0,0,0,1,0,0,0,                0,0,'h100,0,'h22222222,4,0);
        v(0,0,0,0,1,'hAAAA0000,0,       0,0,'h100,1,'hAAAA0000,'h100,0);
        v(0,0,0,0,0,0,1,                1,0,'h100,0,'h33333333,8,0);
        // flush in WAIT, response dropped, next fetch with request stall
        v(1,'h20,0,0,0,0,0,             1,1,'h20,0,'h33333333,8,0);
        v(0,0,0,1,0,0,0,                0,0,'h20,0,'h33333333,8,0);
        v(0,0,1,0,0,0,0,                0,0,'h20,0,'hAAAA0000,'h100,0);
        v(0,0,0,0,1,'hDEADBEEF,0,       0,0,'h20,0,'hAAAA0000,'h100,0);
        v(1,'h40,0,0,0,0,0,             1,1,'h40,0,'hAAAA0000,'h100,0);
        v(0,0,0,0,0,0,0,                0,1,'h40,0,'hAAAA0000,'h100,0);
        v(0,0,0,1,0,0,0,                0,0,'h40,0,'hAAAA0000,'h100,0);
        v(0,0,0,0,1,'h12345678,0,       0,0,'h40,1,'h12345678,'h40,0);
        v(0,0,0,0,0,0,1,                1,0,'h40,0,'h33333333,8,0);
        idle_inputs();
        resetN = 0;
        step();
        step();
        chk_outputs_zero("reset");
        resetN = 1;
        #1;
        chk("reset_release_ar", addrReady, 1);
        for (int i = 0; i < vec.size(); i++) begin
            addrValid = vec[i].av; fetchAddress = vec[i].addr; flush = vec[i].fl;
            memReqReady = vec[i].mrr; memRespValid = vec[i].mrv; memRespData = vec[i].md;
            instrReady = vec[i].ir;
            #1;
            chk($sformatf("r%0d_ar", i), addrReady, vec[i].ar);
            step();
            chk($sformatf("r%0d_mqv", i), memReqValid, vec[i].mqv);
            chk($sformatf("r%0d_mqa", i), memReqAddr, vec[i].mqa);
            chk($sformatf("r%0d_iv", i), instrValid, vec[i].iv);
            chk($sformatf("r%0d_ins", i), instruction, vec[i].ins);
            chk($sformatf("r%0d_ipc", i), instrPC, vec[i].ipc);
            chk($sformatf("r%0d_af", i), alignFault, vec[i].af);
        end
        idle_inputs();
        // flush with a full queue and a simultaneous pop
        fetch('h500, 'hA5);
        fetch('h504, 'hB6);
        chk("full_iv", instrValid, 1);
        chk("full_ins", instruction, 'hA5);
        chk("full_ipc", instrPC, 'h500);
        chk("full_ar", addrReady, 0);
        flush = 1; instrReady = 1;
        #1;
        chk("flush_full_ar", addrReady, 0);
        step();
        flush = 0; instrReady = 0;
        #1;
        chk("flush_full_iv", instrValid, 0);
        chk("flush_full_ar_after", addrReady, 1);
        // flush in REQ while memory stalls withdraws the request
        addrValid = 1; fetchAddress = 'h600;
        step();
        addrValid = 0; flush = 1;
        step();
        flush = 0;
        #1;
        chk("flush_req_stall_mqv", memReqValid, 0);
        chk("flush_req_stall_ar", addrReady, 1);
        // flush in REQ as memory accepts goes to DROP
        addrValid = 1; fetchAddress = 'h604;
        step();
        addrValid = 0; flush = 1; memReqReady = 1;
        step();
        flush = 0; memReqReady = 0;
        #1;
        chk("drop_mqv", memReqValid, 0);
        chk("drop_ar", addrReady, 0);
        memRespValid = 1; memRespData = 'h777;
        step();
        memRespValid = 0;
        #1;
        chk("drop_done_iv", instrValid, 0);
        chk("drop_done_ar", addrReady, 1);
        // flush in WAIT coinciding with the response
        addrValid = 1; fetchAddress = 'h608;
        step();
        addrValid = 0; memReqReady = 1;
        step();
        memReqReady = 0; flush = 1; memRespValid = 1; memRespData = 'h888;
        step();
        flush = 0; memRespValid = 0;
        #1;
        chk("flush_wait_resp_iv", instrValid, 0);
        chk("flush_wait_resp_ar", addrReady, 1);
        // reset asserted in WAIT, stale response after release
        fetch('h700, 'hC7);
        chk("pre_reset_iv", instrValid, 1);
        addrValid = 1; fetchAddress = 'h704;
        step();
        addrValid = 0; memReqReady = 1;
        step();
        memReqReady = 0;
        chk("pre_reset_mqa", memReqAddr, 'h704);
        resetN = 0;
        #1;
        chk_outputs_zero("async_reset");
        step();
        resetN = 1;
        step();
        memRespValid = 1; memRespData = 'hBAD;
        step();
        memRespValid = 0;
        #1;
        chk("stale_iv", instrValid, 0);
        chk("stale_ar", addrReady, 1);
        chk("stale_mqv", memReqValid, 0);
        fetch('h800, 'h99);
        chk("post_reset_iv", instrValid, 1);
        chk("post_reset_ins", instruction, 'h99);
        chk("post_reset_ipc", instrPC, 'h800);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
